knn_feeder: RTL and testbench
=============================

KNN_FEEDER -- requirements
Module: knn_feeder

Interface
REQ-001 SHALL have parameter COORD_WIDTH, default 16, meaning unsigned width of each point coordinate.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the packed point {x,y} width, which equals 2*COORD_WIDTH.
REQ-003 SHALL have parameter TAG_WIDTH, default 32, meaning the distance tag width.
REQ-004 SHALL have parameter CNT_WIDTH, default 16, meaning the counter width.
REQ-005 SHALL have clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have start_in, input, 1 bit: begins a search; query coordinates are latched on the same cycle.
REQ-008 SHALL have query_x_in and query_y_in, input, COORD_WIDTH each: the query point.
REQ-009 SHALL have pt_valid_in, input, 1; pt_data_in, input, DATA_WIDTH, packed {x[hi], y[lo]}; and pt_last_in, input, 1, marking the final candidate.
REQ-010 SHALL have pt_ready_out, output, 1: the candidate is accepted when pt_valid_in and pt_ready_out are both high.
REQ-011 SHALL have q_full_in, input, 1; q_max_tag_in, input, TAG_WIDTH; q_valid_in, input, 1; and q_deq_stall_in, input, 1: downstream queue status.
REQ-012 SHALL have q_enq_out, output, 1; q_enq_data_out, output, DATA_WIDTH; q_enq_tag_out, output, TAG_WIDTH; and q_deq_largest_out, output, 1: downstream queue commands.
REQ-013 SHALL have busy_out, output, 1, and done_out, output, 1, a one-cycle completion pulse.
REQ-014 SHALL have enq_count_out and drop_count_out, output, CNT_WIDTH each: per-search statistics.

Function
REQ-015 SHALL use states IDLE, ACCEPT, DIST1, DIST2, DECIDE, EVICT, WAIT_DEQ, WAIT_REC, ENQ, SETTLE and DONE.
REQ-016 SHALL, in IDLE with start_in high, latch the query, clear both counters, and go to ACCEPT; start_in SHALL be ignored in every other state.
REQ-017 SHALL drive pt_ready_out high only in ACCEPT, so at most one candidate is in flight; a handshake SHALL latch the point and last flag and go to DIST1.
REQ-018 SHALL, in DIST1, register |x-qx| and |y-qy| as COORD_WIDTH-bit magnitudes.
REQ-019 SHALL, in DIST2, register tag = dx^2 + dy^2 computed at 2*COORD_WIDTH+1 bits and saturated to all-ones when the sum exceeds TAG_WIDTH bits.
REQ-020 SHALL, in DECIDE, route as follows:
- q_full_in low: go to ENQ.
- q_full_in high and tag < q_max_tag_in (strict): go to EVICT.
- otherwise: drop the candidate, increment drop_count_out, and go to DONE if last, else ACCEPT.
REQ-021 SHALL, in EVICT, assert q_deq_largest_out for exactly one cycle, then go to WAIT_DEQ.
REQ-022 SHALL, in WAIT_DEQ, wait for q_valid_in high, then go to WAIT_REC.
REQ-023 SHALL, in WAIT_REC, wait for q_deq_stall_in low (downstream max recompute finished), then go to ENQ.
REQ-024 SHALL, in ENQ, assert q_enq_out for exactly one cycle with the stored point and tag, increment enq_count_out, and go to SETTLE.
REQ-025 SHALL hold SETTLE for exactly 2 cycles to cover the downstream registered full/size latency, then go to DONE if last, else ACCEPT.
REQ-026 SHALL, in DONE, pulse done_out for one cycle and return to IDLE.
REQ-027 SHALL drive busy_out high in every state except IDLE.
REQ-028 SHALL let counters wrap modulo 2^CNT_WIDTH.
REQ-029 SHALL hold q_enq_data_out and q_enq_tag_out stable from DECIDE through ENQ.
REQ-030 SHALL sample q_full_in and q_max_tag_in only in DECIDE.

Reset
REQ-031 SHALL, on rst_in low at any time (including mid-EVICT/WAIT states), enter IDLE immediately and drive all outputs to 0, with the latched query, point and tag also cleared.
REQ-032 SHALL leave reset on the first rising clk_in edge after rst_in is high.

Verification
REQ-033 SHALL pass this bench (queue depth 4): query (10,10), one point (13,14), last, queue not full -> tag 25, one q_enq_out pulse 4 cycles after the handshake, done_out pulse, enq_count_out=1.
REQ-034 SHALL pass this bench: query (0,0), point (65535,65535) -> q_enq_tag_out=32'hFFFFFFFF (saturated).
REQ-035 SHALL pass this bench: q_full_in=1, q_max_tag_in=100, candidate tag 25 -> one q_deq_largest_out pulse; no q_enq_out until q_valid_in has been seen and q_deq_stall_in is low; then q_enq_out with tag 25.
REQ-036 SHALL pass this bench: q_full_in=1, q_max_tag_in=100, candidate tag 100 -> no queue commands, drop_count_out=1.
REQ-037 SHALL pass this bench: stream of 6 points into an empty depth-4 queue -> pt_ready_out never high while busy with a prior point; at least 2 cycles between q_enq_out pulses; enq_count_out+drop_count_out=6.
REQ-038 SHALL pass this bench: rst_in low while in WAIT_DEQ -> busy_out=0 and all outputs 0 with no clock edge; a new start_in after release is accepted.

Source files
------------

// File: rtl/knn_feeder.sv
// ---------------------------------------------------------------------------
// knn_feeder
// Feeds candidate points into a downstream bounded "k smallest distances"
// queue.  For every candidate it computes the squared Euclidean distance to a
// latched query point, then either enqueues it directly (queue not full),
// evicts the current largest entry and enqueues it (queue full and candidate
// strictly closer), or drops it.  One candidate is processed at a time.
//
// Ports
//   clk_in, rst_in          : clock, asynchronous active-low reset
//   start_in                : begin a search, latches query_x_in/query_y_in
//   query_x_in, query_y_in  : query point coordinates
//   pt_valid_in/pt_ready_out: candidate handshake; pt_data_in = {x, y}
//   pt_last_in              : marks the final candidate of a search
//   q_full_in, q_max_tag_in : downstream queue full flag and largest tag
//   q_valid_in              : downstream dequeue completed
//   q_deq_stall_in          : downstream still recomputing its maximum
//   q_enq_out (+data, tag)  : enqueue command
//   q_deq_largest_out       : evict-largest command
//   busy_out, done_out      : search active / one-cycle completion pulse
//   enq_count_out, drop_count_out : per-search statistics (wrap on overflow)
// ---------------------------------------------------------------------------
module knn_feeder #(
   parameter int COORD_WIDTH = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int TAG_WIDTH   = 32,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   start_in,
   input  logic [COORD_WIDTH-1:0] query_x_in,
   input  logic [COORD_WIDTH-1:0] query_y_in,
   input  logic                   pt_valid_in,
   input  logic [DATA_WIDTH-1:0]  pt_data_in,
   input  logic                   pt_last_in,
   output logic                   pt_ready_out,
   input  logic                   q_full_in,
   input  logic [TAG_WIDTH-1:0]   q_max_tag_in,
   input  logic                   q_valid_in,
   input  logic                   q_deq_stall_in,
   output logic                   q_enq_out,
   output logic [DATA_WIDTH-1:0]  q_enq_data_out,
   output logic [TAG_WIDTH-1:0]   q_enq_tag_out,
   output logic                   q_deq_largest_out,
   output logic                   busy_out,
   output logic                   done_out,
   output logic [CNT_WIDTH-1:0]   enq_count_out,
   output logic [CNT_WIDTH-1:0]   drop_count_out
);

   // Sum of two squares needs one bit more than a single square.
   localparam int SUM_W = 2*COORD_WIDTH + 1;
   localparam int EXT_W = (SUM_W > TAG_WIDTH) ? SUM_W : TAG_WIDTH;

   typedef enum logic [3:0] {
      IDLE,
      ACCEPT,
      DIST1,
      DIST2,
      DECIDE,
      EVICT,
      WAIT_DEQ,
      WAIT_REC,
      ENQ,
      SETTLE,
      DONE
   } stateT;

   stateT                  state_q,  state_d;
   logic [COORD_WIDTH-1:0] queryX_q, queryX_d;
   logic [COORD_WIDTH-1:0] queryY_q, queryY_d;
   logic [DATA_WIDTH-1:0]  point_q,  point_d;
   logic                   last_q,   last_d;
   logic [COORD_WIDTH-1:0] dx_q,     dx_d;
   logic [COORD_WIDTH-1:0] dy_q,     dy_d;
   logic [TAG_WIDTH-1:0]   tag_q,    tag_d;
   logic [CNT_WIDTH-1:0]   enqCnt_q, enqCnt_d;
   logic [CNT_WIDTH-1:0]   dropCnt_q, dropCnt_d;
   logic                   settle_q, settle_d;

   logic [COORD_WIDTH-1:0] pointX;
   logic [COORD_WIDTH-1:0] pointY;
   logic [SUM_W-1:0]       sumFull;
   logic [EXT_W-1:0]       sumExt;
   logic                   sumOverflow;
   logic [TAG_WIDTH-1:0]   tagSat;

   assign pointX = point_q[COORD_WIDTH +: COORD_WIDTH];
   assign pointY = point_q[0 +: COORD_WIDTH];

   // Squares are computed at full precision; anything that does not fit in
   // the tag width saturates so very distant points still order correctly.
   assign sumFull     = SUM_W'(dx_q) * SUM_W'(dx_q) + SUM_W'(dy_q) * SUM_W'(dy_q);
   assign sumExt      = EXT_W'(sumFull);
   assign sumOverflow = |(sumExt >> TAG_WIDTH);
   assign tagSat      = sumOverflow ? {TAG_WIDTH{1'b1}} : sumExt[TAG_WIDTH-1:0];

   // The stored point and tag are presented continuously; they only change at
   // a handshake or in DIST2, so they are stable from DECIDE through ENQ.
   assign q_enq_data_out = point_q;
   assign q_enq_tag_out  = tag_q;
   assign enq_count_out  = enqCnt_q;
   assign drop_count_out = dropCnt_q;

   // State register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers; all cleared by reset so outputs read zero.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         queryX_q  <= '0;
         queryY_q  <= '0;
         point_q   <= '0;
         last_q    <= 1'b0;
         dx_q      <= '0;
         dy_q      <= '0;
         tag_q     <= '0;
         enqCnt_q  <= '0;
         dropCnt_q <= '0;
         settle_q  <= 1'b0;
      end else begin
         queryX_q  <= queryX_d;
         queryY_q  <= queryY_d;
         point_q   <= point_d;
         last_q    <= last_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         tag_q     <= tag_d;
         enqCnt_q  <= enqCnt_d;
         dropCnt_q <= dropCnt_d;
         settle_q  <= settle_d;
      end
   end

   // Next-state and output decode.  Commands are pure functions of the state,
   // so each command state yields exactly a one-cycle pulse.
   always_comb begin
      state_d           = state_q;
      queryX_d          = queryX_q;
      queryY_d          = queryY_q;
      point_d           = point_q;
      last_d            = last_q;
      dx_d              = dx_q;
      dy_d              = dy_q;
      tag_d             = tag_q;
      enqCnt_d          = enqCnt_q;
      dropCnt_d         = dropCnt_q;
      settle_d          = settle_q;
      pt_ready_out      = 1'b0;
      q_enq_out         = 1'b0;
      q_deq_largest_out = 1'b0;
      done_out          = 1'b0;
      busy_out          = (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (start_in) begin
               queryX_d  = query_x_in;
               queryY_d  = query_y_in;
               enqCnt_d  = '0;
               dropCnt_d = '0;
               state_d   = ACCEPT;
            end
         end
         ACCEPT: begin
            pt_ready_out = 1'b1;
            if (pt_valid_in) begin
               point_d = pt_data_in;
               last_d  = pt_last_in;
               state_d = DIST1;
            end
         end
         DIST1: begin
            dx_d    = (pointX >= queryX_q) ? (pointX - queryX_q) : (queryX_q - pointX);
            dy_d    = (pointY >= queryY_q) ? (pointY - queryY_q) : (queryY_q - pointY);
            state_d = DIST2;
         end
         DIST2: begin
            tag_d   = tagSat;
            state_d = DECIDE;
         end
         DECIDE: begin
            if (!q_full_in) begin
               state_d = ENQ;
            end else if (tag_q < q_max_tag_in) begin
               state_d = EVICT;
            end else begin
               dropCnt_d = dropCnt_q + CNT_WIDTH'(1);
               state_d   = last_q ? DONE : ACCEPT;
            end
         end
         EVICT: begin
            q_deq_largest_out = 1'b1;
            state_d           = WAIT_DEQ;
         end
         WAIT_DEQ: begin
            if (q_valid_in) begin
               state_d = WAIT_REC;
            end
         end
         WAIT_REC: begin
            if (!q_deq_stall_in) begin
               state_d = ENQ;
            end
         end
         ENQ: begin
            q_enq_out = 1'b1;
            enqCnt_d  = enqCnt_q + CNT_WIDTH'(1);
            settle_d  = 1'b0;
            state_d   = SETTLE;
         end
         SETTLE: begin
            // Two cycles so the queue's registered full/max reflect this entry.
            if (settle_q) begin
               state_d = last_q ? DONE : ACCEPT;
            end else begin
               settle_d = 1'b1;
            end
         end
         DONE: begin
            done_out = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_knn_feeder.sv
module tb_knn_feeder;

   localparam int CW    = 16;
   localparam int DW    = 32;
   localparam int TW    = 32;
   localparam int NW    = 16;
   localparam int DEPTH = 4;

   typedef struct {
      logic [DW-1:0] data;
      logic [TW-1:0] tag;
      bit            evict;
   } expT;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          startIn = 1'b0;
   logic [CW-1:0] queryX = '0;
   logic [CW-1:0] queryY = '0;
   logic          ptValid = 1'b0;
   logic [DW-1:0] ptData = '0;
   logic          ptLast = 1'b0;
   logic          ptReady;
   logic          qFull = 1'b0;
   logic [TW-1:0] qMax = '0;
   logic          qValid = 1'b0;
   logic          qStall = 1'b0;
   logic          qEnq;
   logic [DW-1:0] qEnqData;
   logic [TW-1:0] qEnqTag;
   logic          qDeq;
   logic          busyOut;
   logic          doneOut;
   logic [NW-1:0] enqCnt;
   logic [NW-1:0] dropCnt;

   int checkCount = 0;
   int errorCount = 0;
   int doneCnt = 0;
   int expEnqCnt = 0;
   int expDropCnt = 0;
   bit holdValid = 0;

   expT           expQ[$];
   logic [TW-1:0] modelTags[$];
   logic [TW-1:0] emuTags[$];
   logic [CW-1:0] ptX[8];
   logic [CW-1:0] ptY[8];

   knn_feeder #(
      .COORD_WIDTH(CW),
      .DATA_WIDTH(DW),
      .TAG_WIDTH(TW),
      .CNT_WIDTH(NW)
   ) dut (
      .clk_in(clk),
      .rst_in(rstN),
      .start_in(startIn),
      .query_x_in(queryX),
      .query_y_in(queryY),
      .pt_valid_in(ptValid),
      .pt_data_in(ptData),
      .pt_last_in(ptLast),
      .pt_ready_out(ptReady),
      .q_full_in(qFull),
      .q_max_tag_in(qMax),
      .q_valid_in(qValid),
      .q_deq_stall_in(qStall),
      .q_enq_out(qEnq),
      .q_enq_data_out(qEnqData),
      .q_enq_tag_out(qEnqTag),
      .q_deq_largest_out(qDeq),
      .busy_out(busyOut),
      .done_out(doneOut),
      .enq_count_out(enqCnt),
      .drop_count_out(dropCnt)
   );

   // 100 MHz free-running clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Reference model: distance from the rules, then decide against an ideal
   // bounded queue holding the k smallest tags; the expected command is queued.
   task automatic modelStep(input logic [CW-1:0] qx, input logic [CW-1:0] qy,
                            input logic [CW-1:0] x, input logic [CW-1:0] y);
      longint  dx, dy, s;
      logic [TW-1:0] tag;
      int      mi;
      expT     e;
      dx = (x >= qx) ? longint'(x) - longint'(qx) : longint'(qx) - longint'(x);
      dy = (y >= qy) ? longint'(y) - longint'(qy) : longint'(qy) - longint'(y);
      s  = dx*dx + dy*dy;
      tag = (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
      e.data  = {x, y};
      e.tag   = tag;
      e.evict = 0;
      if (modelTags.size() < DEPTH) begin
         modelTags.push_back(tag);
         expQ.push_back(e);
         expEnqCnt++;
      end else begin
         mi = 0;
         for (int i = 1; i < modelTags.size(); i++) begin
            if (modelTags[i] > modelTags[mi]) mi = i;
         end
         if (tag < modelTags[mi]) begin
            modelTags.delete(mi);
            modelTags.push_back(tag);
            e.evict = 1;
            expQ.push_back(e);
            expEnqCnt++;
         end else begin
            expDropCnt++;
         end
      end
   endtask

   // Offer one candidate and wait (bounded) for its handshake.
   task automatic applyStimulus(input logic [DW-1:0] data, input logic last);
      int cnt;
      ptValid = 1'b1;
      ptData  = data;
      ptLast  = last;
      cnt = 0;
      @(negedge clk);
      while (!ptReady && cnt < 300) begin
         @(negedge clk);
         cnt++;
      end
      checkOutput("handshake_timeout", ptReady, 1);
      @(posedge clk);
      #1;
      ptValid = 1'b0;
      ptLast  = 1'b0;
      ptData  = $urandom;
   endtask

   // Empty both the ideal queue and the emulated downstream queue.
   task automatic clearQueues();
      modelTags.delete();
      emuTags.delete();
   endtask

   task automatic addTag(input logic [TW-1:0] t);
      modelTags.push_back(t);
      emuTags.push_back(t);
   endtask

   // One complete search over ptX/ptY[0..n-1]; optionally pokes start_in while
   // busy with a junk query, which must be ignored.
   task automatic runSearch(input logic [CW-1:0] qx, input logic [CW-1:0] qy,
                            input int n, input bit pokeStart);
      int startDone;
      int cnt;
      startDone  = doneCnt;
      expEnqCnt  = 0;
      expDropCnt = 0;
      @(posedge clk);
      #1;
      startIn = 1'b1;
      queryX  = qx;
      queryY  = qy;
      @(posedge clk);
      #1;
      startIn = 1'b0;
      queryX  = $urandom;
      queryY  = $urandom;
      for (int i = 0; i < n; i++) begin
         if (pokeStart && i > 0 && ($urandom % 2) == 1) begin
            startIn = 1'b1;
            @(posedge clk);
            #1;
            startIn = 1'b0;
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         modelStep(qx, qy, ptX[i], ptY[i]);
         applyStimulus({ptX[i], ptY[i]}, (i == n-1));
      end
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (busyOut && cnt < 500);
      checkOutput("search_completes", busyOut, 0);
      checkOutput("done_once", doneCnt - startDone, 1);
   endtask

   // Monitor + downstream queue emulator: compares every command the DUT
   // issues against the scoreboard, and answers evictions with randomly
   // delayed q_valid_in / q_deq_stall_in like a real queue would.
   initial begin : monitor
      int  sinceHs;
      int  sinceEnq;
      bit  prevDone, prevDeq, prevEnq;
      bit  evictDone, validSeen;
      int  phase, validDelay, stallDelay, mi;
      expT e;
      sinceHs = 100; sinceEnq = 100;
      prevDone = 0; prevDeq = 0; prevEnq = 0;
      evictDone = 0; validSeen = 0;
      phase = 0; validDelay = 0; stallDelay = 0;
      forever begin
         @(negedge clk);
         if (!rstN) begin
            sinceHs = 100; sinceEnq = 100;
            prevDone = 0; prevDeq = 0; prevEnq = 0;
            evictDone = 0; validSeen = 0; phase = 0;
            qValid = 1'b0;
            qStall = 1'b0;
            continue;
         end
         if (sinceHs < 100) sinceHs++;
         if (sinceEnq < 100) sinceEnq++;

         if (ptReady) begin
            checkOutput("ready_while_point_in_flight", sinceHs >= 4, 1);
            checkOutput("ready_during_settle", sinceEnq >= 3, 1);
         end
         if (sinceEnq == 3) begin
            checkOutput("settle_exit_cycle", ptReady || doneOut, 1);
         end
         if (ptValid && ptReady) sinceHs = 0;

         // Emulated dequeue response.
         case (phase)
            1: begin
               validDelay--;
               if (validDelay == 0) begin
                  qValid = 1'b1;
                  validSeen = 1;
                  phase = 2;
               end
            end
            2: begin
               qValid = 1'b0;
               stallDelay = $urandom_range(0, 3);
               if (stallDelay == 0) begin
                  qStall = 1'b0;
                  phase = 0;
               end else begin
                  phase = 4;
               end
            end
            4: begin
               stallDelay--;
               if (stallDelay == 0) begin
                  qStall = 1'b0;
                  phase = 0;
               end
            end
            default: ;
         endcase

         if (qDeq) begin
            checkOutput("deq_single_cycle", prevDeq, 0);
            checkOutput("deq_expected", (expQ.size() != 0) && expQ[0].evict && !evictDone, 1);
            if (emuTags.size() != 0) begin
               mi = 0;
               for (int i = 1; i < emuTags.size(); i++) begin
                  if (emuTags[i] > emuTags[mi]) mi = i;
               end
               emuTags.delete(mi);
            end
            evictDone  = 1;
            qStall     = 1'b1;
            validDelay = 1 + $urandom_range(0, 3);
            phase      = holdValid ? 3 : 1;
         end

         if (qEnq) begin
            checkOutput("enq_single_cycle", prevEnq, 0);
            checkOutput("enq_expected", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               checkOutput("enq_data", qEnqData, e.data);
               checkOutput("enq_tag", qEnqTag, e.tag);
               if (e.evict) begin
                  checkOutput("enq_after_deq", evictDone, 1);
                  checkOutput("enq_after_valid", validSeen, 1);
                  checkOutput("enq_stall_low", qStall, 0);
               end else begin
                  checkOutput("enq_latency", sinceHs, 4);
               end
            end
            emuTags.push_back(qEnqTag);
            evictDone = 0;
            validSeen = 0;
            sinceEnq  = 0;
         end

         if (doneOut) begin
            checkOutput("done_single_cycle", prevDone, 0);
            checkOutput("done_enq_count", enqCnt, expEnqCnt);
            checkOutput("done_drop_count", dropCnt, expDropCnt);
            checkOutput("done_all_enqueued", expQ.size(), 0);
            doneCnt++;
         end

         qFull = (emuTags.size() >= DEPTH);
         qMax  = '0;
         for (int i = 0; i < emuTags.size(); i++) begin
            if (emuTags[i] > qMax) qMax = emuTags[i];
         end
         prevDone = doneOut;
         prevDeq  = qDeq;
         prevEnq  = qEnq;
      end
   end

   // Bound on total run time.
   initial begin : watchdog
      #2_000_000;
      errorCount++;
      $display("[TB] FAIL watchdog: actual=timeout expected=finish");
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, directed cases, randomized searches, mid-wait reset.
   initial begin : stimulus
      int n;
      logic [CW-1:0] qx, qy;

      #1;
      checkOutput("reset_ready", ptReady, 0);
      checkOutput("reset_enq", qEnq, 0);
      checkOutput("reset_data", qEnqData, 0);
      checkOutput("reset_tag", qEnqTag, 0);
      checkOutput("reset_deq", qDeq, 0);
      checkOutput("reset_busy", busyOut, 0);
      checkOutput("reset_done", doneOut, 0);
      checkOutput("reset_enq_count", enqCnt, 0);
      checkOutput("reset_drop_count", dropCnt, 0);
      #20;
      rstN = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] single point into empty queue");
      clearQueues();
      ptX[0] = 16'd13; ptY[0] = 16'd14;
      runSearch(16'd10, 16'd10, 1, 0);
      checkOutput("single_enq_count", enqCnt, 1);
      checkOutput("single_tag_25", qEnqTag, 25);

      $display("[TB] saturated distance");
      clearQueues();
      ptX[0] = 16'hFFFF; ptY[0] = 16'hFFFF;
      runSearch(16'd0, 16'd0, 1, 0);
      checkOutput("saturated_tag", qEnqTag, 32'hFFFF_FFFF);

      $display("[TB] full queue, closer candidate evicts");
      clearQueues();
      addTag(100); addTag(50); addTag(30); addTag(10);
      ptX[0] = 16'd13; ptY[0] = 16'd14;
      runSearch(16'd10, 16'd10, 1, 0);
      checkOutput("evict_enq_count", enqCnt, 1);
      checkOutput("evict_tag_25", qEnqTag, 25);

      $display("[TB] full queue, equal tag is dropped");
      clearQueues();
      addTag(100); addTag(50); addTag(30); addTag(10);
      ptX[0] = 16'd16; ptY[0] = 16'd18;
      runSearch(16'd10, 16'd10, 1, 0);
      checkOutput("equal_drop_count", dropCnt, 1);
      checkOutput("equal_enq_count", enqCnt, 0);

      $display("[TB] six point stream into empty queue");
      clearQueues();
      for (int i = 0; i < 6; i++) begin
         ptX[i] = 16'($urandom_range(0, 40));
         ptY[i] = 16'($urandom_range(0, 40));
      end
      runSearch(16'd20, 16'd20, 6, 1);
      checkOutput("stream_total", enqCnt + dropCnt, 6);

      $display("[TB] randomized searches");
      for (int s = 0; s < 24; s++) begin
         clearQueues();
         n = $urandom_range(0, DEPTH);
         for (int i = 0; i < n; i++) addTag(32'($urandom_range(0, 1500)));
         qx = 16'($urandom_range(0, 30));
         qy = 16'($urandom_range(0, 30));
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               ptX[i] = 16'($urandom);
               ptY[i] = 16'($urandom);
            end else begin
               ptX[i] = 16'($urandom_range(0, 60));
               ptY[i] = 16'($urandom_range(0, 60));
            end
         end
         runSearch(qx, qy, n, 1);
      end

      $display("[TB] reset while waiting for dequeue");
      clearQueues();
      addTag(100); addTag(50); addTag(30); addTag(10);
      holdValid = 1;
      expEnqCnt = 0;
      expDropCnt = 0;
      @(posedge clk);
      #1;
      startIn = 1'b1; queryX = 16'd10; queryY = 16'd10;
      @(posedge clk);
      #1;
      startIn = 1'b0;
      modelStep(16'd10, 16'd10, 16'd13, 16'd14);
      applyStimulus({16'd13, 16'd14}, 1'b1);
      repeat (8) @(negedge clk);
      checkOutput("wait_deq_busy", busyOut, 1);
      checkOutput("wait_deq_no_enq_yet", expQ.size(), 1);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("midreset_busy", busyOut, 0);
      checkOutput("midreset_ready", ptReady, 0);
      checkOutput("midreset_enq", qEnq, 0);
      checkOutput("midreset_data", qEnqData, 0);
      checkOutput("midreset_tag", qEnqTag, 0);
      checkOutput("midreset_deq", qDeq, 0);
      checkOutput("midreset_done", doneOut, 0);
      checkOutput("midreset_enq_count", enqCnt, 0);
      checkOutput("midreset_drop_count", dropCnt, 0);
      expQ.delete();
      clearQueues();
      holdValid = 0;
      repeat (2) @(posedge clk);
      #3;
      rstN = 1'b1;
      ptX[0] = 16'd3; ptY[0] = 16'd4;
      runSearch(16'd0, 16'd0, 1, 0);
      checkOutput("post_reset_tag", qEnqTag, 25);
      checkOutput("post_reset_enq_count", enqCnt, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
